// File: rtl/mt_sink_pkg.sv
// Shared constants and width helpers for the MouseTrap synchronous sink.
// MT_SINK_SYNC3_EN selects a 3-flop request synchronizer instead of 2.
package mt_sink_pkg;

`ifdef MT_SINK_SYNC3_EN
  localparam int SYNC_STAGES = 3;
`else
  localparam int SYNC_STAGES = 2;
`endif

  // Read/write pointer width for a power-of-two FIFO depth.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mt_req_sync.sv
// Flop-chain synchronizer that brings the 2-phase request into the clock domain.
// Depth comes from mt_sink_pkg::SYNC_STAGES, which MT_SINK_SYNC3_EN controls.
module mt_req_sync
  import mt_sink_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic srst,
  input  logic i_async,
  output logic o_sync
);

  // Attribute keeps the chain intact and placed together as a synchronizer.
  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (srst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[STAGES-1];

endmodule

// File: rtl/mousetrap_sync_sink.sv
// Terminates a MouseTrap 2-phase bundled-data pipeline into a valid/ready FIFO.
// MT_SINK_SYNC3_EN (see mt_sink_pkg) lengthens the request synchronizer to 3 flops.
module mousetrap_sync_sink
  import mt_sink_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     extReset,
  input  logic                     ReqIn,
  input  logic [WIDTH-1:0]         DataIn,
  output logic                     AckOut,
  output logic                     OutValid,
  output logic [WIDTH-1:0]         OutData,
  input  logic                     OutReady,
  output logic [lvl_w(DEPTH)-1:0]  Level
);

  localparam int PW = ptr_w(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  logic             w_req_sync;
  logic             w_pending;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  logic             r_req_seen;
  logic             r_ack;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_mem [DEPTH];

  mt_req_sync #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk     (Clk),
    .srst    (extReset),
    .i_async (ReqIn),
    .o_sync  (w_req_sync)
  );

  // A token is pending whenever the synchronized phase differs from the last one accepted.
  assign w_pending = w_req_sync ^ r_req_seen;
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_push    = w_pending & ~w_full;
  assign w_pop     = OutValid & OutReady;

  always_ff @(posedge Clk) begin
    if (extReset) begin
      r_req_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
    end else begin
      if (w_push) begin
        r_req_seen <= w_req_sync;
        r_ack      <= ~r_ack;
        r_wr_ptr   <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage is not reset; DataIn is held stable by the sender until AckOut toggles.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DataIn;
    end
  end

  assign AckOut   = r_ack;
  assign OutValid = (r_level != '0);
  assign OutData  = r_mem[r_rd_ptr];
  assign Level    = r_level;

endmodule

// File: tb/tb_mousetrap_sync_sink.sv
// Self-checking bench for mousetrap_sync_sink: directed scenarios plus random traffic
// checked every cycle against a queue-based model of the sink.
module tb_mousetrap_sync_sink;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
`ifdef MT_SINK_SYNC3_EN
  localparam int N = 3;
`else
  localparam int N = 2;
`endif

  logic             Clk = 1'b0;
  logic             tb_rst;
  logic             tb_req;
  logic             tb_rdy;
  logic [WIDTH-1:0] tb_din;
  logic             AckOut;
  logic             OutValid;
  logic [WIDTH-1:0] OutData;
  logic [1:0]       Level;

  always #5 Clk = ~Clk;

  mousetrap_sync_sink #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .Clk      (Clk),
    .extReset (tb_rst),
    .ReqIn    (tb_req),
    .DataIn   (tb_din),
    .AckOut   (AckOut),
    .OutValid (OutValid),
    .OutData  (OutData),
    .OutReady (tb_rdy),
    .Level    (Level)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: FIFO contents, ack phase, last accepted request phase,
  // and edges elapsed since the sender last toggled ReqIn.
  logic [WIDTH-1:0] q[$];
  logic             m_ack  = 1'b0;
  logic             m_seen = 1'b0;
  int               m_cnt  = 100;
  logic [WIDTH-1:0] dut_pops[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("ack", 32'(AckOut), 32'(m_ack));
    chk("valid", 32'(OutValid), 32'(q.size() != 0));
    chk("level", 32'(Level), 32'(q.size()));
    if (q.size() != 0) chk("data", 32'(OutData), 32'(q[0]));
  endtask

  // One clock: decide push/pop from pre-edge model state, advance, then check at negedge.
  task automatic cycle();
    bit do_push;
    bit do_pop;
    do_push = !tb_rst && (tb_req != m_seen) && (m_cnt >= N) && (q.size() < DEPTH);
    do_pop  = !tb_rst && (q.size() > 0) && tb_rdy;
    if (!tb_rst && OutValid && tb_rdy) dut_pops.push_back(OutData);
    @(posedge Clk);
    if (tb_rst) begin
      q.delete();
      m_ack  = 1'b0;
      m_seen = 1'b0;
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(tb_din);
        m_seen = tb_req;
        m_ack  = ~m_ack;
      end
    end
    if (m_cnt < 100) m_cnt++;
    @(negedge Clk);
    check_outputs();
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    tb_din = d;
    tb_req = ~tb_req;
    m_cnt  = 0;
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 40 && m_seen != tb_req; i++) cycle();
    chk(tag, 32'(AckOut), 32'(tb_req));
  endtask

  initial begin
    tb_rst = 1'b1;
    tb_req = 1'b0;
    tb_rdy = 1'b0;
    tb_din = '0;

    // Reset held two cycles with the sender idle.
    repeat (2) cycle();
    tb_rst = 1'b0;
    cycle();
    chk("rst_level", 32'(Level), 32'd0);
    chk("rst_ack", 32'(AckOut), 32'd0);
    chk("rst_valid", 32'(OutValid), 32'd0);

    // Single token: visible exactly N+1 edges after ReqIn is first sampled.
    send(8'hA5);
    repeat (N) cycle();
    chk("single_early", 32'(OutValid), 32'd0);
    cycle();
    chk("single_data", 32'(OutData), 32'hA5);
    chk("single_ack", 32'(AckOut), 32'd1);
    chk("single_level", 32'(Level), 32'd1);
    tb_rdy = 1'b1;
    cycle();
    tb_rdy = 1'b0;
    chk("single_drain", 32'(Level), 32'd0);

    // Backpressure: third token stays pending until a pop frees a slot.
    send(8'h11);
    wait_ack("bp_ack1");
    send(8'h22);
    wait_ack("bp_ack2");
    send(8'h33);
    repeat (8) cycle();
    chk("bp_level", 32'(Level), 32'd2);
    chk("bp_ack_held", 32'(AckOut), 32'(!tb_req));
    chk("bp_head", 32'(OutData), 32'h11);
    tb_rdy = 1'b1;
    cycle();
    tb_rdy = 1'b0;
    chk("bp_pop_level", 32'(Level), 32'd1);
    chk("bp_head2", 32'(OutData), 32'h22);
    chk("bp_ack_still", 32'(AckOut), 32'(!tb_req));
    cycle();
    chk("bp_push_level", 32'(Level), 32'd2);
    chk("bp_ack_toggle", 32'(AckOut), 32'(tb_req));
    tb_rdy = 1'b1;
    repeat (3) cycle();
    tb_rdy = 1'b0;
    chk("bp_empty", 32'(Level), 32'd0);

    // Wrap-around streaming with the consumer always ready.
    dut_pops.delete();
    tb_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(8'(i));
      wait_ack("wrap_ack");
      chk("wrap_level_max", 32'(Level > 2'd1), 32'd0);
    end
    repeat (3) cycle();
    tb_rdy = 1'b0;
    chk("wrap_count", 32'(dut_pops.size()), 32'd10);
    for (int i = 0; i < dut_pops.size(); i++) chk("wrap_order", 32'(dut_pops[i]), 32'(i));

    // Simultaneous push and pop at Level=1.
    send(8'h5A);
    wait_ack("sim_ack1");
    send(8'hC3);
    repeat (N) cycle();
    chk("sim_pre_level", 32'(Level), 32'd1);
    tb_rdy = 1'b1;
    cycle();
    tb_rdy = 1'b0;
    chk("sim_level", 32'(Level), 32'd1);
    chk("sim_head", 32'(OutData), 32'hC3);
    chk("sim_ack", 32'(AckOut), 32'(tb_req));
    tb_rdy = 1'b1;
    cycle();
    tb_rdy = 1'b0;

    // Reset mid-stream with a token pending, sender reset alongside.
    send(8'h01);
    wait_ack("mr_ack1");
    send(8'h02);
    wait_ack("mr_ack2");
    send(8'h03);
    repeat (N + 2) cycle();
    chk("mr_level_pre", 32'(Level), 32'd2);
    tb_rst = 1'b1;
    tb_req = 1'b0;
    m_cnt  = 0;
    repeat (2) cycle();
    tb_rst = 1'b0;
    repeat (8) cycle();
    chk("mr_level", 32'(Level), 32'd0);
    chk("mr_ack", 32'(AckOut), 32'd0);
    chk("mr_valid", 32'(OutValid), 32'd0);

    // Random traffic: random consumer readiness and sender idle gaps.
    for (int i = 0; i < 400; i++) begin
      tb_rdy = 1'($urandom_range(0, 1));
      if (tb_req == m_seen && $urandom_range(0, 2) == 0) send(8'($urandom_range(0, 255)));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
